// File: rtl/pe_demux_router.sv
// pe_demux_router
//   Registered 1:NUM_OUT demultiplexer with valid/ready flow control.
//   The input beat goes to one output channel. The channel is chosen by
//   in_sel in explicit mode, or by the internal round-robin pointer in
//   round-robin mode. Each channel holds one registered entry. A stalled
//   consumer therefore blocks only the beats that target its own channel.
//
//   Optional feature: define PE_DEMUX_BCAST_EN to enable broadcast. When
//   in_bcast=1, one beat loads every channel. Without the macro, in_bcast
//   is ignored.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : input handshake
//   in_data  [WIDTH]    : input payload
//   in_sel   [SEL_W]    : explicit target channel (rr_mode=0)
//   rr_mode             : 1 = round-robin steering, 0 = explicit
//   in_bcast            : broadcast request (PE_DEMUX_BCAST_EN only)
//   out_valid[NUM_OUT]  : per-channel valid
//   out_ready[NUM_OUT]  : per-channel consumer ready
//   out_data [NUM_OUT*WIDTH] : channel i at [i*WIDTH +: WIDTH]
//   rr_ptr   [SEL_W]    : current round-robin pointer
module pe_demux_router #(
  parameter int WIDTH   = 8,
  parameter int NUM_OUT = 4,
  parameter int SEL_W   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     rr_mode,
  input  logic                     in_bcast,
  output logic [NUM_OUT-1:0]       out_valid,
  input  logic [NUM_OUT-1:0]       out_ready,
  output logic [NUM_OUT*WIDTH-1:0] out_data,
  output logic [SEL_W-1:0]         rr_ptr
);

  logic [NUM_OUT-1:0]            r_valid;
  logic [NUM_OUT-1:0][WIDTH-1:0] r_data;
  logic [SEL_W-1:0]              r_rr_ptr;

  logic [NUM_OUT-1:0] w_free;
  logic [NUM_OUT-1:0] w_load;
  logic [SEL_W-1:0]   w_tgt;
  logic               w_bcast;
  logic               w_acc;

`ifdef PE_DEMUX_BCAST_EN
  assign w_bcast = in_bcast;
`else
  // Broadcast is compiled out. Tying it to 0 lets synthesis drop the logic.
  logic w_unused;
  assign w_unused = in_bcast;
  assign w_bcast  = 1'b0;
`endif

  // A slot is free when it is empty or being drained this cycle.
  // This allows a drain and a refill of the same slot in one cycle.
  assign w_free   = ~r_valid | out_ready;
  assign w_tgt    = rr_mode ? r_rr_ptr : in_sel;
  assign in_ready = w_bcast ? (&w_free) : w_free[w_tgt];
  assign w_acc    = in_valid & in_ready;

  for (genvar i = 0; i < NUM_OUT; i++) begin : g_lane
    assign w_load[i] = w_acc & (w_bcast | (w_tgt == SEL_W'(i)));

    always_ff @(posedge clk) begin
      if (rst) begin
        r_valid[i] <= 1'b0;
        r_data[i]  <= '0;
      end else if (w_load[i]) begin
        r_valid[i] <= 1'b1;
        r_data[i]  <= in_data;
      end else if (out_ready[i]) begin
        // out_data keeps its value after a drain; only valid clears.
        r_valid[i] <= 1'b0;
      end
    end
  end

  // The pointer width equals log2(NUM_OUT), so wrap-around is the natural overflow.
  always_ff @(posedge clk) begin
    if (rst)
      r_rr_ptr <= '0;
    else if (w_acc && rr_mode && !w_bcast)
      r_rr_ptr <= r_rr_ptr + SEL_W'(1);
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign rr_ptr    = r_rr_ptr;

endmodule

// File: doc/pe_demux_router.md
# pe_demux_router

Parametrised, registered 1:N demultiplexer with valid/ready flow control for the PE datapath. A single input stream is steered to one of `NUM_OUT` output channels, selected either explicitly by `in_sel` or automatically in round-robin order. Each output channel holds one registered entry, so a stalled consumer blocks only beats addressed to its own channel. This block replaces fixed-width, unbuffered 1:4 steering in the PE array.

## Interface
Parameters:
- `WIDTH`, 8: data width per beat.
- `NUM_OUT`, 4: number of output channels; power of two, 2 to 16.
- `SEL_W`, 2: select width; must equal log2(`NUM_OUT`).

Ports:
- `clk`, input, 1: the single clock; all state updates on the rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `in_valid`, input, 1: input beat present.
- `in_ready`, output, 1: block accepts the beat this cycle.
- `in_data`, input, `WIDTH`: input payload.
- `in_sel`, input, `SEL_W`: target channel, used when `rr_mode`=0.
- `rr_mode`, input, 1: 1 selects round-robin steering, 0 selects explicit steering.
- `in_bcast`, input, 1: broadcast request; effective only with `PE_DEMUX_BCAST_EN`.
- `out_valid`, output, `NUM_OUT`: per-channel valid; bit i is channel i.
- `out_ready`, input, `NUM_OUT`: per-channel consumer ready.
- `out_data`, output, `NUM_OUT*WIDTH`: channel i occupies `[i*WIDTH +: WIDTH]`.
- `rr_ptr`, output, `SEL_W`: current round-robin pointer.

## Operation
- Target channel t:
  - t = `rr_ptr` when `rr_mode`=1.
  - t = `in_sel` when `rr_mode`=0.
- Slot i is free when `out_valid[i]`=0 or `out_ready[i]`=1, so a drain and a refill can happen in the same cycle.
- `in_ready` is combinational: it equals "slot t free" in unicast and "all slots free" in broadcast.
- Accept occurs when `in_valid` and `in_ready` are both 1.
  - On accept, channel t loads `in_data` and sets `out_valid[t]`=1.
- Drain occurs when `out_valid[i]` and `out_ready[i]` are both 1.
  - Without a simultaneous load, `out_valid[i]` clears.
  - With a simultaneous load, `out_valid[i]` stays 1 and the data is replaced.
- `out_data[i]` holds its value while `out_valid[i]`=0. No channel ever drops or overwrites an undrained beat.
- Round-robin pointer:
  - Increments by 1 only on an accepted beat while `rr_mode`=1.
  - Wraps from `NUM_OUT`-1 to 0.
  - Holds when `rr_mode`=0; explicit-mode beats do not move it.
  - A mode switch does not reset it; round-robin resumes from the held value.
- The input must hold `in_data`, `in_sel`, `in_bcast` and `in_valid` stable until accepted. The bench asserts this; the RTL does not check it.

## Timing
- Reset: `out_valid`=0, all `out_data`=0, `rr_ptr`=0. `in_ready` then follows combinationally and is 1 for any target.
- Reset has priority over accept and drain in the same cycle; beats held at reset are discarded.
- Latency: a beat accepted in cycle n appears on `out_valid[t]`/`out_data` in cycle n+1.
- Throughput: one beat per cycle when the target consumer keeps `out_ready`=1.
- No combinational path exists from `in_valid`/`in_data` to any output. The only combinational paths are `out_ready`, `in_sel`, `rr_mode` and `in_bcast` to `in_ready`.

## Configuration
- `PE_DEMUX_BCAST_EN` defined:
  - When `in_bcast`=1, an accepted beat loads every channel and sets all `out_valid` bits.
  - `in_ready` requires every slot to be free.
  - `rr_ptr` does not advance on a broadcast beat.
- `PE_DEMUX_BCAST_EN` undefined:
  - `in_bcast` is ignored and every beat is unicast.
  - No broadcast logic is synthesised.

## Test plan
- Reset check: assert `rst` for 2 cycles, then release → `out_valid`=0, `out_data`=0, `rr_ptr`=0, `in_ready`=1.
- Explicit steering (`NUM_OUT`=4, `WIDTH`=8): send `in_sel`=2, `in_data`=8'hA5 → cycle+1 `out_valid`=4'b0100 and channel 2 = 8'hA5.
- Backpressure: channel 1 full with `out_ready[1]`=0, then send a second beat to channel 1 → `in_ready`=0 and 8'h11 held. A beat to channel 3 in the same state is accepted.
- Round-robin wrap: `rr_mode`=1, stream 5 beats 8'h01..8'h05 with all `out_ready`=1 → beats land on channels 0,1,2,3,0 and `rr_ptr` ends at 1.
- Simultaneous drain/refill: channel 0 valid with `out_ready[0]`=1 and a new beat 8'h77 to channel 0 in the same cycle → `in_ready`=1, `out_valid[0]` stays 1, data 8'h77.
- Broadcast (macro defined): all slots free, `in_bcast`=1, `in_data`=8'h3C → all 4 channels 8'h3C and `rr_ptr` unchanged. With one slot full and stalled → `in_ready`=0.
